// File: rtl/not_share_arbiter.sv
// rtl/not_share_arbiter.sv - round-robin arbiter sharing one W-bit NOT datapath among N requesters
module not_share_arbiter #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] op,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   s,
  output logic [N-1:0]   done,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n, idx, idx_n, pick;
  logic          found;
  logic [W-1:0]  opnd, opnd_n, s_n;
  logic [N-1:0]  gnt_n, done_n;
  logic          busy_n;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int k);
    int t;
    t = int'(a) + k;
    if (t >= N) t = t - N;
    return IW'(t);
  endfunction

  // First requester at or after ptr, circularly.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_add(ptr, k)]) begin
        found = 1'b1;
        pick  = wrap_add(ptr, k);
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    opnd_n  = opnd;
    s_n     = s;
    gnt_n   = gnt;
    done_n  = done;
    busy_n  = busy;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          idx_n       = pick;
          opnd_n      = op[pick*W +: W];
          busy_n      = 1'b1;
          state_n     = EXEC;
        end
      end
      EXEC: begin
        s_n     = ~opnd;
        done_n  = gnt;
        state_n = RESP;
      end
      RESP: begin
        done_n  = '0;
        gnt_n   = '0;
        busy_n  = 1'b0;
        ptr_n   = (idx == IW'(N-1)) ? '0 : idx + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      opnd  <= '0;
      s     <= '0;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      idx   <= idx_n;
      opnd  <= opnd_n;
      s     <= s_n;
      gnt   <= gnt_n;
      done  <= done_n;
      busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_not_share_arbiter.sv
// tb/tb_not_share_arbiter.sv - randomized and directed bench for not_share_arbiter
module tb_not_share_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] op;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   s;
  logic           busy;

  int checks = 0;
  int failures = 0;

  // transaction-level reference: who is being served and how far along
  int         m_cur;
  int         m_age;
  int         m_ptr;
  logic [7:0] m_opnd, m_s;
  int         gq[$];
  logic [7:0] sq[$];

  not_share_arbiter #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op),
    .gnt(gnt), .s(s), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] o);
    if (!r) begin
      m_cur = -1; m_age = 0; m_ptr = 0; m_s = 8'h00; m_opnd = 8'h00;
    end else if (m_cur < 0) begin
      if (rq != '0) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (m_cur < 0 && rq[j]) m_cur = j;
        end
        m_opnd = o[m_cur*W +: W];
        m_age = 0;
        gq.push_back(m_cur);
      end
    end else if (m_age == 0) begin
      m_s = ~m_opnd;
      m_age = 1;
      sq.push_back(m_s);
    end else begin
      m_ptr = (m_cur + 1) % N;
      m_cur = -1;
      m_age = 0;
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] o);
    logic [N-1:0] eg, ed;
    rst_n = r; req = rq; op = o;
    @(posedge clk);
    model_edge(r, rq, o);
    #1;
    eg = (m_cur >= 0) ? (N'(1) << m_cur) : '0;
    ed = (m_cur >= 0 && m_age == 1) ? eg : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("done", 32'(done), 32'(ed));
    chk("s", 32'(s), 32'(m_s));
    chk("busy", 32'(busy), 32'(m_cur >= 0));
  endtask

  initial begin
    int exp_g[5];
    logic [7:0] exp_s[5];
    m_cur = -1; m_age = 0; m_ptr = 0; m_s = 0; m_opnd = 0;
    rst_n = 1'b0; req = '0; op = '0;

    // reset with everything requesting
    step(0, 4'b1111, 32'hFFFF_FFFF);
    step(0, 4'b1111, 32'hFFFF_FFFF);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_s", 32'(s), 0);

    // single request from requester 2
    step(1, 4'b0100, 32'h005A_0000);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_busy", 32'(busy), 1);
    step(1, 4'b0100, 32'h005A_0000);
    chk("single_s", 32'(s), 32'hA5);
    chk("single_done", 32'(done), 32'h4);
    step(1, 4'b0000, 32'h005A_0000);
    chk("single_clr", 32'({gnt, done, busy}), 0);
    chk("single_hold", 32'(s), 32'hA5);

    // round robin from ptr=0
    step(0, 4'b0000, 32'h0);
    gq.delete(); sq.delete();
    for (int c = 0; c < 15; c++) step(1, 4'b1111, 32'hFFF0_0F00);
    exp_g = '{0, 1, 2, 3, 0};
    exp_s = '{8'hFF, 8'hF0, 8'h0F, 8'h00, 8'hFF};
    chk("rr_count", 32'(gq.size()), 5);
    for (int i = 0; i < 5 && i < gq.size() && i < sq.size(); i++) begin
      chk("rr_order", 32'(gq[i]), 32'(exp_g[i]));
      chk("rr_s", 32'(sq[i]), 32'(exp_s[i]));
    end

    // pointer wrap: serve 3, then 0 wins over 3
    gq.delete();
    for (int c = 0; c < 3; c++) step(1, 4'b1000, 32'h0);
    for (int c = 0; c < 6; c++) step(1, 4'b1001, 32'h0);
    chk("wrap_count", 32'(gq.size()), 3);
    if (gq.size() == 3) begin
      chk("wrap_a", 32'(gq[0]), 3);
      chk("wrap_b", 32'(gq[1]), 0);
      chk("wrap_c", 32'(gq[2]), 3);
    end

    // operand hold: op[1] changes during EXEC
    step(1, 4'b0010, 32'h0000_0000);
    chk("hold_gnt", 32'(gnt), 32'h2);
    step(1, 4'b0000, 32'h0000_3C00);
    chk("hold_s", 32'(s), 32'hFF);
    chk("hold_done", 32'(done), 32'h2);
    step(1, 4'b0000, 32'h0000_3C00);

    // reset at the EXEC edge of requester 2
    step(1, 4'b0100, 32'h0011_0000);
    chk("midrst_gnt0", 32'(gnt), 32'h4);
    step(0, 4'b0100, 32'h0011_0000);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_s", 32'(s), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    step(1, 4'b1111, 32'h0011_0000);
    chk("midrst_next", 32'(gnt), 32'h1);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++)
      step(($urandom % 60) != 0, N'($urandom), $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
